apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//  APB completer (slave) with a small memory-mapped register file for a low-power peripheral.
//  Sits on the far side of the team's APB master: it decodes PADDR, returns PRDATA/PREADY/PSLVERR,
//  and exposes the register contents and write strobes to peripheral logic.
//  The top register is a read-only status word, and errors are counted.
// PARAMETERS
//  ADDR_WIDTH   16  APB address width (byte address)
//  DATA_WIDTH   32  APB data width and register width
//  NUM_REGS     8   number of registers (>=2); reg NUM_REGS-1 is read-only status
//  WAIT_CYCLES  2   wait states per transfer (1..15); used only when APB_SLV_WAIT_EN is defined
// PORTS
//  clk       in   1                     clock
//  rst_n     in   1                     reset, asynchronous, active-low
//  PADDR     in   ADDR_WIDTH            APB address
//  PSEL      in   1                     APB select
//  PENABLE   in   1                     APB enable (access phase)
//  PWRITE    in   1                     1=write, 0=read
//  PWDATA    in   DATA_WIDTH            APB write data
//  PRDATA    out  DATA_WIDTH            APB read data
//  PREADY    out  1                     APB ready
//  PSLVERR   out  1                     APB slave error
//  status_in in   DATA_WIDTH            value returned when reading reg NUM_REGS-1
//  reg_out   out  NUM_REGS*DATA_WIDTH   RW register contents; reg i at [i*DW +: DW]; top slice is 0
//  wr_pulse  out  NUM_REGS              1-cycle strobe, bit i set in the cycle after reg i is written
//  err_cnt   out  8                     count of PSLVERR responses, saturates at 8'hFF
// BEHAVIOUR
//  Reset: all registers, PRDATA, wr_pulse and err_cnt are 0; PREADY=0; PSLVERR=0; state=IDLE.
//  Decode: idx = PADDR[ADDR_WIDTH-1:2].
//   - PADDR[1:0]!=0 -> error.
//   - idx>=NUM_REGS -> error.
//   - write to idx==NUM_REGS-1 -> error.
//   - An errored write updates nothing; an errored read returns PRDATA=0.
//  FSM states: IDLE, WAIT, ACCESS.
//   - IDLE: PSEL=1 and PENABLE=0 is a setup cycle. On it, latch addr/write/data, the error flag,
//     and the read data. Read data is sampled from the register (or status_in) at the setup edge.
//     Next state is ACCESS, or WAIT when APB_SLV_WAIT_EN is defined.
//   - WAIT: PREADY=0. A down-counter is loaded with WAIT_CYCLES at setup; go to ACCESS when it
//     reaches 1. Sequence: setup, then WAIT_CYCLES cycles with PREADY=0, then a cycle with PREADY=1.
//   - ACCESS: PREADY = PSEL & PENABLE (combinational). The transfer completes at the edge where
//     PSEL&PENABLE&PREADY. On completion: a write with no error commits PWDATA, wr_pulse[idx] is set
//     the next cycle, and the FSM returns to IDLE.
//  Outputs outside the completion cycle:
//   - PSLVERR = error flag & PREADY; it is 0 whenever PREADY=0.
//   - PRDATA = latched data only while PREADY=1 and the transfer is a read, else 0.
//  Back-to-back: a setup cycle immediately after a completion is accepted (IDLE sees it that cycle).
//  Aborts:
//   - PSEL=0 in WAIT or ACCESS -> return to IDLE; no write, no error count.
//   - PENABLE=1 seen in IDLE -> ignored (no setup); no response.
//  err_cnt increments on each completed errored transfer and holds at 255.
//  Reset asserted mid-transfer clears everything immediately; a pending write is lost.
//  wr_pulse is all-zero except the single cycle after a committed write.
// CONFIGURATION
//  APB_SLV_WAIT_EN defined: every transfer inserts WAIT_CYCLES wait states via the WAIT state and counter.
//  Not defined: WAIT state and counter are absent; zero-wait transfers (PREADY=1 in the first access cycle).
// TESTING  (NUM_REGS=8, DW=32; macro off unless noted)
//  1. Write 0x1234_5678 to 0x0004, then read 0x0004 -> PRDATA=0x1234_5678, PSLVERR=0;
//     wr_pulse=8'h02 for 1 cycle; reg_out[63:32] updated.
//  2. status_in=0xCAFE_F00D, read 0x001C -> PRDATA=0xCAFE_F00D. Write 0x001C -> PSLVERR=1,
//     status unchanged, err_cnt=1.
//  3. Read 0x0020 and write 0x0006 -> each PSLVERR=1 with PREADY=1; read PRDATA=0; no register
//     change; err_cnt increments by 2.
//  4. APB_SLV_WAIT_EN, WAIT_CYCLES=3: write 0x0000 -> exactly 3 access cycles with PREADY=0, then
//     PREADY=1; write commits only on the PREADY=1 edge.
//  5. Back-to-back write 0x0008=0xA5A5_A5A5 then read 0x0008 with no idle cycle -> read returns
//     0xA5A5_A5A5.
//  6. Drop PSEL during WAIT, then assert rst_n=0 mid-transfer -> no commit; all outputs return to
//     reset values; next transfer completes normally.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS x DATA_WIDTH register file; the top register is read-only status.
// APB_SLV_WAIT_EN inserts WAIT_CYCLES wait states per transfer; otherwise transfers complete with zero wait states.
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [7:0]                     err_cnt
);

  localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int AIW = ADDR_WIDTH - 2;

`ifdef APB_SLV_WAIT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;
  logic [3:0] wait_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACCESS} state_t;
`endif

  state_t                                state;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs;
  logic [IW-1:0]                         lat_sel;
  logic                                  lat_write;
  logic                                  lat_err;
  logic [DATA_WIDTH-1:0]                 lat_rdata;

  logic [AIW-1:0]        dec_idx;
  logic [IW-1:0]         dec_sel;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] dec_rdata;
  logic                  complete;

  assign dec_idx = PADDR[ADDR_WIDTH-1:2];
  assign dec_sel = dec_idx[IW-1:0];
  assign dec_err = (PADDR[1:0] != 2'b00)
                 | (dec_idx >= AIW'(NUM_REGS))
                 | (PWRITE & (dec_idx == AIW'(NUM_REGS-1)));

  // Read data is captured at the setup edge; errored reads and all writes capture zero.
  always_comb begin
    dec_rdata = '0;
    if (!dec_err && !PWRITE) begin
      if (dec_idx == AIW'(NUM_REGS-1)) dec_rdata = status_in;
      else                             dec_rdata = regs[dec_sel];
    end
  end

  assign complete = (state == S_ACCESS) & PSEL & PENABLE;
  assign PREADY   = complete;
  assign PSLVERR  = lat_err & PREADY;
  assign PRDATA   = (PREADY & ~lat_write) ? lat_rdata : '0;
  assign reg_out  = regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      regs      <= '0;
      lat_sel   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_rdata <= '0;
      wr_pulse  <= '0;
      err_cnt   <= 8'h00;
`ifdef APB_SLV_WAIT_EN
      wait_cnt  <= 4'd0;
`endif
    end else begin
      wr_pulse <= '0;
      case (state)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            lat_sel   <= dec_sel;
            lat_write <= PWRITE;
            lat_err   <= dec_err;
            lat_rdata <= dec_rdata;
`ifdef APB_SLV_WAIT_EN
            wait_cnt  <= 4'(WAIT_CYCLES);
            state     <= S_WAIT;
`else
            state     <= S_ACCESS;
`endif
          end
        end
`ifdef APB_SLV_WAIT_EN
        S_WAIT: begin
          if (!PSEL)                 state    <= S_IDLE;
          else if (wait_cnt <= 4'd1) state    <= S_ACCESS;
          else                       wait_cnt <= wait_cnt - 4'd1;
        end
`endif
        S_ACCESS: begin
          if (!PSEL) begin
            state <= S_IDLE;
          end else if (PENABLE) begin
            // Completion edge: the top register is never written since such writes carry lat_err.
            if (lat_write && !lat_err) begin
              regs[lat_sel]     <= PWDATA;
              wr_pulse[lat_sel] <= 1'b1;
            end
            if (lat_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a scoreboard of predicted responses is checked at each completion.
module tb_apb_slave_regfile;

  logic         clk;
  logic         rst_n;
  logic [15:0]  PADDR;
  logic         PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [31:0]  PRDATA;
  logic         PREADY;
  logic         PSLVERR;
  logic [31:0]  status_in;
  logic [255:0] reg_out;
  logic [7:0]   wr_pulse;
  logic [7:0]   err_cnt;

`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAITS = 3;
`else
  localparam int EXP_WAITS = 0;
`endif

  apb_slave_regfile #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_REGS(8), .WAIT_CYCLES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .status_in(status_in), .reg_out(reg_out),
    .wr_pulse(wr_pulse), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  pulse;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [8];
  int          mdl_err;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    e   = '0;
    idx = int'(addr[15:2]);
    e.err = (addr[1:0] != 2'b00) || (idx >= 8) || (wr && idx == 7);
    if (e.err) begin
      if (mdl_err < 255) mdl_err++;
    end else if (wr) begin
      mdl[idx] = data;
      e.pulse  = 8'(1 << idx);
    end else begin
      e.rdata = (idx == 7) ? status_in : mdl[idx];
    end
    return e;
  endfunction

  function automatic logic [255:0] mdl_regs();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = mdl[i];
    return r;
  endfunction

  // Entered and left at posedge+1; leaves the bus idle so a following call makes it back-to-back.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    exp_t g;
    int   waits;
    int   budget;
    logic done;
    sb.push_back(predict(wr, addr, data));
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    #1;
    check("setup_pready", PREADY, 1'b0);
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #1;
    check("pulse_one_cycle", wr_pulse, 8'h00);
    waits = 0; budget = 0; done = 1'b0;
    g = '0;
    while (!done && budget < 40) begin
      if (PREADY) begin
        g = sb.pop_front();
        check("prdata", PRDATA, g.rdata);
        check("pslverr", PSLVERR, g.err);
        done = 1'b1;
      end else begin
        check("pslverr_wait", PSLVERR, 1'b0);
        check("prdata_wait", PRDATA, 32'h0);
        waits++;
        budget++;
        @(posedge clk); #2;
      end
    end
    check("completed", done, 1'b1);
    check("wait_states", waits, EXP_WAITS);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("wr_pulse", wr_pulse, done ? g.pulse : 8'h00);
    check("err_cnt", err_cnt, mdl_err);
    check("reg_out", reg_out, mdl_regs());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_prdata"}, PRDATA, 32'h0);
    check({tag, "_pready"}, PREADY, 1'b0);
    check({tag, "_pslverr"}, PSLVERR, 1'b0);
    check({tag, "_reg_out"}, reg_out, 256'h0);
    check({tag, "_wr_pulse"}, wr_pulse, 8'h00);
    check({tag, "_err_cnt"}, err_cnt, 8'h00);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; mdl_err = 0;
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    rst_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 16'h0; PWDATA = 32'h0; status_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write / read-back
    xfer(1'b1, 16'h0004, 32'h1234_5678);
    xfer(1'b0, 16'h0004, 32'h0);
    check("reg1_slice", reg_out[63:32], 32'h1234_5678);

    // Status register: readable, write rejected
    status_in = 32'hCAFE_F00D;
    xfer(1'b0, 16'h001C, 32'h0);
    xfer(1'b1, 16'h001C, 32'h5555_5555);
    check("status_after_write", reg_out[255:224], 32'h0);
    check("err_cnt_1", err_cnt, 8'd1);

    // Out-of-range read and misaligned write
    xfer(1'b0, 16'h0020, 32'h0);
    xfer(1'b1, 16'h0006, 32'hFFFF_FFFF);
    check("err_cnt_3", err_cnt, 8'd3);

    // Register 0 write, then back-to-back write/read of register 2
    xfer(1'b1, 16'h0000, 32'h0BEE_F001);
    xfer(1'b1, 16'h0008, 32'hA5A5_A5A5);
    xfer(1'b0, 16'h0008, 32'h0);
    xfer(1'b1, 16'h0018, 32'h6666_0006);
    xfer(1'b0, 16'h0018, 32'h0);

    // PENABLE without a setup cycle is ignored
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 16'h0004; PWDATA = 32'hBAD0_0001;
    #1;
    check("no_setup_pready0", PREADY, 1'b0);
    @(posedge clk); #1;
    check("no_setup_pready1", PREADY, 1'b0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    check("no_setup_regs", reg_out, mdl_regs());
    check("no_setup_pulse", wr_pulse, 8'h00);

    // Abort by dropping PSEL after setup
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h000C; PWDATA = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    PSEL = 1'b0;
    #1;
    check("abort_pready", PREADY, 1'b0);
    @(posedge clk); #1;
    check("abort_regs", reg_out, mdl_regs());
    check("abort_pulse", wr_pulse, 8'h00);
    check("abort_err_cnt", err_cnt, mdl_err);

    // Reset in the access phase of a write
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0010; PWDATA = 32'h1111_2222;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    mdl_err = 0;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 16'h0010, 32'h0BAD_F00D);
    xfer(1'b0, 16'h0010, 32'h0);

    // Error counter saturation
    for (int i = 0; i < 257; i++) xfer(1'b0, 16'h0020, 32'h0);
    check("err_cnt_sat", err_cnt, 8'hFF);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
